video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 121 ++++++++++++
 tb/tb_video_timing_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing and test-pattern source: frame/line windows plus h-ramp, v-ramp,
// checker or LFSR pixel data, with a one-cycle registered output stage.
module video_timing_gen #(
    parameter int DW      = 8,
    parameter int H_ACT   = 1920,
    parameter int H_BLANK = 280,
    parameter int V_ACT   = 1080,
    parameter int V_BLANK = 45,
    parameter int HW      = 12,
    parameter int VW      = 11
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          en,
    input  logic [1:0]    pat_sel,
    output logic          vvalid,
    output logic          hvalid,
    output logic [DW-1:0] dout,
    output logic          frame_done,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [HW-1:0] H_LAST     = HW'(H_ACT + H_BLANK - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_ACT + V_BLANK - 1);
    localparam logic [HW-1:0] H_END      = HW'(H_ACT);
    localparam logic [VW-1:0] V_END      = VW'(V_ACT);
    localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

    state_t          state, state_nxt;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic [1:0]      pat_q;
    logic [15:0]     lfsr;
    logic            h_last, v_last, eof, act_line, act_pix;
    logic [15:0]     h16, v16;
    logic [DW-1:0]   pix;

    assign h_last   = (hcnt == H_LAST);
    assign v_last   = (vcnt == V_LAST);
    assign eof      = h_last && v_last;
    assign act_line = (state != IDLE) && (vcnt < V_END);
    assign act_pix  = act_line && (hcnt < H_END);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_b) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            // Dropping en exactly on the last cycle means the frame is already complete.
            RUN:     if (!en) state_nxt = eof ? IDLE : DRAIN;
            DRAIN:   if (en) state_nxt = RUN;
                     else if (eof) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_b || state == IDLE) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Pattern and LFSR seed only change at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst_b)
            pat_q <= 2'd0;
        else if (state_nxt == RUN && (state == IDLE || eof))
            pat_q <= pat_sel;
    end

    always_ff @(posedge clk) begin
        if (rst_b || state == IDLE || eof)
            lfsr <= LFSR_SEED;
        else if (act_pix)
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign h16 = 16'(hcnt);
    assign v16 = 16'(vcnt);

    always_comb begin
        pix = '0;
        case (pat_q)
            2'd0: pix = h16[DW-1:0];
            2'd1: pix = v16[DW-1:0];
            2'd2: pix = (h16[4] ^ v16[4]) ? '1 : '0;
            2'd3: pix = lfsr[DW-1:0];
            default: pix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            vvalid     <= 1'b0;
            hvalid     <= 1'b0;
            dout       <= '0;
            frame_done <= 1'b0;
        end else begin
            vvalid     <= act_line;
            hvalid     <= act_pix;
            dout       <= act_pix ? pix : '0;
            frame_done <= (state != IDLE) && eof;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on an 8x4 active / 12x6 total raster,
// checking every output cycle of each frame against an expected-value model.
module tb_video_timing_gen;

    localparam int H_TOT = 12;
    localparam int V_TOT = 6;
    localparam int F_LEN = H_TOT * V_TOT;

    logic       clk;
    logic       rst_b;
    logic       en;
    logic [1:0] pat_sel;
    logic       vvalid;
    logic       hvalid;
    logic [7:0] dout;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int fnum   = 0;

    logic [7:0] lfsr_hand [4] = '{8'hE1, 8'hC3, 8'h87, 8'h0F};

    video_timing_gen #(
        .DW(8), .H_ACT(8), .H_BLANK(4), .V_ACT(4), .V_BLANK(2), .HW(12), .VW(11)
    ) dut (
        .clk(clk), .rst_b(rst_b), .en(en), .pat_sel(pat_sel),
        .vvalid(vvalid), .hvalid(hvalid), .dout(dout),
        .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " vvalid"}, 32'(vvalid), 0);
        check({tag, " hvalid"}, 32'(hvalid), 0);
        check({tag, " dout"}, 32'(dout), 0);
        check({tag, " frame_done"}, 32'(frame_done), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    // Entered positioned on output cycle 0 of a frame; leaves on cycle 0 of the next.
    task automatic frame_check(input int pat,
                               input int c1, input logic en1, input logic [1:0] p1,
                               input int c2, input logic en2, input logic [1:0] p2,
                               input logic busy_end);
        int hv_n = 0, vv_n = 0, fd_n = 0, act_i = 0;
        logic [15:0] lf = 16'hACE1;
        fnum++;
        for (int c = 0; c < F_LEN; c++) begin
            int h = c % H_TOT;
            int v = c / H_TOT;
            logic ehv, evv;
            logic [7:0] exp_d;
            string t;
            ehv = (v < 4) && (h < 8);
            evv = (v < 4);
            case (pat)
                0: exp_d = 8'(h);
                1: exp_d = 8'(v);
                2: exp_d = (((h >> 4) ^ (v >> 4)) & 1) != 0 ? 8'hFF : 8'h00;
                default: exp_d = lf[7:0];
            endcase
            if (!ehv) exp_d = 8'h00;
            t = $sformatf("f%0d c%0d", fnum, c);
            check({t, " hvalid"}, 32'(hvalid), 32'(ehv));
            check({t, " vvalid"}, 32'(vvalid), 32'(evv));
            check({t, " dout"}, 32'(dout), 32'(exp_d));
            check({t, " frame_done"}, 32'(frame_done), (c == F_LEN - 1) ? 1 : 0);
            check({t, " busy"}, 32'(busy), (c == F_LEN - 1) ? 32'(busy_end) : 1);
            if (ehv) begin
                if (pat == 3 && act_i < 4)
                    check({t, " lfsr_hand"}, 32'(dout), 32'(lfsr_hand[act_i]));
                act_i++;
                lf = lfsr_next(lf);
            end
            hv_n += int'(hvalid);
            vv_n += int'(vvalid);
            fd_n += int'(frame_done);
            if (c == c1) begin en = en1; pat_sel = p1; end
            if (c == c2) begin en = en2; pat_sel = p2; end
            step();
        end
        check($sformatf("f%0d hvalid_count", fnum), 32'(hv_n), 32);
        check($sformatf("f%0d vvalid_count", fnum), 32'(vv_n), 48);
        check($sformatf("f%0d frame_done_count", fnum), 32'(fd_n), 1);
    endtask

    initial begin
        rst_b   = 1'b1;
        en      = 1'b0;
        pat_sel = 2'd0;
        step();
        step();
        check_idle("reset");

        rst_b = 1'b0;
        step();
        check("idle busy", 32'(busy), 0);

        // Start: busy after edge k, first pixel after edge k+1.
        en = 1'b1;
        step();
        check("start busy", 32'(busy), 1);
        check("start hvalid", 32'(hvalid), 0);
        check("start vvalid", 32'(vvalid), 0);
        step();

        // F1 h-ramp; pat_sel changed to 1 at once but only takes effect next frame.
        frame_check(0, 0, 1'b1, 2'd1, -1, 1'b1, 2'd1, 1'b1);
        // F2, F3 v-ramp; switch to LFSR in line 2 of F3.
        frame_check(1, -1, 1'b1, 2'd1, -1, 1'b1, 2'd1, 1'b1);
        frame_check(1, 30, 1'b1, 2'd3, -1, 1'b1, 2'd3, 1'b1);
        // F4, F5 LFSR, identical sequences; en dropped in line 2 of F5.
        frame_check(3, -1, 1'b1, 2'd3, -1, 1'b1, 2'd3, 1'b1);
        frame_check(3, 26, 1'b0, 2'd3, -1, 1'b0, 2'd3, 1'b0);

        for (int i = 0; i < 4; i++) begin
            check_idle($sformatf("post_drain %0d", i));
            step();
        end

        // F6: en dropped then re-raised during DRAIN; F7 follows with no gap.
        en      = 1'b1;
        pat_sel = 2'd0;
        step();
        check("restart busy", 32'(busy), 1);
        step();
        frame_check(0, 20, 1'b0, 2'd0, 40, 1'b1, 2'd0, 1'b1);

        // F7: reset during an active pixel (h=3, v=1).
        for (int i = 0; i < 15; i++) step();
        check("pre_reset hvalid", 32'(hvalid), 1);
        check("pre_reset dout", 32'(dout), 3);
        rst_b = 1'b1;
        step();
        check_idle("mid_reset");
        rst_b   = 1'b0;
        pat_sel = 2'd2;
        step();
        check("post_reset busy", 32'(busy), 1);
        check("post_reset hvalid", 32'(hvalid), 0);
        step();
        // F8 checker pattern from a fresh (0,0).
        frame_check(2, -1, 1'b1, 2'd2, -1, 1'b1, 2'd2, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
